// File: rtl/game_pkg.sv
// Shared types and constants for the binary-counting game blocks.
package game_pkg;
  localparam int TICK_DIV_DEFAULT = 1000;
  localparam int TIME_W           = 8;
  localparam int PRESC_W          = 16;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} round_state_t;
endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to one-cycle game-time ticks; holds its count while en is low.
module tick_prescaler
  import game_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= (cnt == LAST) ? '0 : cnt + PRESC_W'(1);
  end

  // Tick marks the cycle whose closing edge wraps the count.
  assign tick = en && (cnt == LAST);
endmodule

// File: rtl/round_timer.sv
// Per-round elapsed-time counter feeding the blink controller and the game FSM.
module round_timer
  import game_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [TIME_W-1:0] max_time,
  output logic [TIME_W-1:0] timer_value,
  output logic [TIME_W-1:0] max_time_q,
  output logic              running,
  output logic              timeout,
  output logic              expired,
  output logic              stopped
);
  round_state_t      state;
  logic              tick;
  logic [TIME_W-1:0] timer_inc;

  assign timer_inc = timer_value + TIME_W'(1);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (state == RUN),
    .clr  (start),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer_value <= '0;
      max_time_q  <= '0;
      running     <= 1'b0;
      timeout     <= 1'b0;
      expired     <= 1'b0;
      stopped     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (start) begin
        timer_value <= '0;
        max_time_q  <= max_time;
        stopped     <= 1'b0;
        // A zero-length round expires on the spot.
        if (max_time == '0) begin
          state   <= DONE;
          running <= 1'b0;
          expired <= 1'b1;
          timeout <= 1'b1;
        end else begin
          state   <= RUN;
          running <= 1'b1;
          expired <= 1'b0;
        end
      end else begin
        case (state)
          RUN: begin
            if (stop) begin
              state   <= DONE;
              running <= 1'b0;
              stopped <= 1'b1;
            end else if (tick) begin
              timer_value <= timer_inc;
              if (timer_inc == max_time_q) begin
                state   <= DONE;
                running <= 1'b0;
                expired <= 1'b1;
                timeout <= 1'b1;
              end else if (pause) begin
                state <= PAUSE;
              end
            end else if (pause) begin
              state <= PAUSE;
            end
          end
          PAUSE: begin
            if (stop) begin
              state   <= DONE;
              running <= 1'b0;
              stopped <= 1'b1;
            end else if (!pause) begin
              state <= RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_round_timer.sv
// Directed scoreboard bench for round_timer with a short tick period.
module tb_round_timer;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [7:0] max_time = 8'd0;
  logic [7:0] timer_value, max_time_q;
  logic       running, timeout, expired, stopped;

  round_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .max_time(max_time), .timer_value(timer_value), .max_time_q(max_time_q),
    .running(running), .timeout(timeout), .expired(expired), .stopped(stopped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] tv, mq;
    logic       run, to, ex, st;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0, errors = 0;
  int   to_cnt = 0;
  bit   run_seen = 0;

  task automatic chk(string tag, int got, int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic cmp(string tag, logic [7:0] tv, logic [7:0] mq, logic run, logic to, logic ex, logic st);
    chk({tag, ".timer_value"}, int'(timer_value), int'(tv));
    chk({tag, ".max_time_q"},  int'(max_time_q),  int'(mq));
    chk({tag, ".running"},     int'(running),     int'(run));
    chk({tag, ".timeout"},     int'(timeout),     int'(to));
    chk({tag, ".expired"},     int'(expired),     int'(ex));
    chk({tag, ".stopped"},     int'(stopped),     int'(st));
  endtask

  function automatic void push(int c, string tag, logic [7:0] tv, logic [7:0] mq,
                               logic run, logic to, logic ex, logic st);
    exp_t e;
    e.cyc = c; e.tag = tag; e.tv = tv; e.mq = mq;
    e.run = run; e.to = to; e.ex = ex; e.st = st;
    q.push_back(e);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: pop every expectation whose cycle has been reached.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (timeout === 1'b1) to_cnt++;
    if (running === 1'b1) run_seen = 1;
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk({e.tag, ".cycle"}, cyc, e.cyc);
      cmp(e.tag, e.tv, e.mq, e.run, e.to, e.ex, e.st);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) step();
  endtask

  task automatic start_round(logic [7:0] mt, output int e);
    start = 1'b1;
    max_time = mt;
    e = cyc + 1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int e, e2, e3, e4;

    // Reset state
    step(); step();
    cmp("rst_held", 8'd0, 8'd0, 0, 0, 0, 0);
    rst = 1'b0;
    step(); step();
    cmp("rst_released", 8'd0, 8'd0, 0, 0, 0, 0);
    pause = 1'b1; stop = 1'b1;
    step();
    pause = 1'b0; stop = 1'b0;
    step();
    cmp("idle_ignores", 8'd0, 8'd0, 0, 0, 0, 0);

    // Normal expiry, max_time=3
    to_cnt = 0;
    start_round(8'd3, e);
    push(e,      "exp_e0",  8'd0, 8'd3, 1, 0, 0, 0);
    push(e + 3,  "exp_e3",  8'd0, 8'd3, 1, 0, 0, 0);
    push(e + 4,  "exp_e4",  8'd1, 8'd3, 1, 0, 0, 0);
    push(e + 8,  "exp_e8",  8'd2, 8'd3, 1, 0, 0, 0);
    push(e + 11, "exp_e11", 8'd2, 8'd3, 1, 0, 0, 0);
    push(e + 12, "exp_e12", 8'd3, 8'd3, 0, 1, 1, 0);
    push(e + 13, "exp_e13", 8'd3, 8'd3, 0, 0, 1, 0);
    wait_until(e + 16);
    chk("exp_timeout_pulses", to_cnt, 1);

    // Player answer, stop at E+6
    to_cnt = 0;
    start_round(8'd5, e);
    push(e,      "ans_e0",  8'd0, 8'd5, 1, 0, 0, 0);
    push(e + 4,  "ans_e4",  8'd1, 8'd5, 1, 0, 0, 0);
    push(e + 6,  "ans_e6",  8'd1, 8'd5, 0, 0, 0, 1);
    push(e + 16, "ans_e16", 8'd1, 8'd5, 0, 0, 0, 1);
    push(e + 26, "ans_e26", 8'd1, 8'd5, 0, 0, 0, 1);
    wait_until(e + 5);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_until(e + 27);
    chk("ans_timeout_pulses", to_cnt, 0);

    // Pause for 3 cycles starting E+2, max_time=2
    to_cnt = 0;
    start_round(8'd2, e);
    push(e + 2,  "pau_e2",  8'd0, 8'd2, 1, 0, 0, 0);
    push(e + 6,  "pau_e6",  8'd0, 8'd2, 1, 0, 0, 0);
    push(e + 7,  "pau_e7",  8'd1, 8'd2, 1, 0, 0, 0);
    push(e + 10, "pau_e10", 8'd1, 8'd2, 1, 0, 0, 0);
    push(e + 11, "pau_e11", 8'd2, 8'd2, 0, 1, 1, 0);
    push(e + 12, "pau_e12", 8'd2, 8'd2, 0, 0, 1, 0);
    wait_until(e + 1);
    pause = 1'b1;
    wait_until(e + 4);
    pause = 1'b0;
    wait_until(e + 14);
    chk("pau_timeout_pulses", to_cnt, 1);

    // Stop coinciding with the final tick
    to_cnt = 0;
    start_round(8'd2, e);
    push(e + 4,  "col_e4",  8'd1, 8'd2, 1, 0, 0, 0);
    push(e + 8,  "col_e8",  8'd1, 8'd2, 0, 0, 0, 1);
    push(e + 12, "col_e12", 8'd1, 8'd2, 0, 0, 0, 1);
    wait_until(e + 7);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_until(e + 13);
    chk("col_timeout_pulses", to_cnt, 0);

    // Zero-length round
    to_cnt = 0;
    run_seen = 0;
    start_round(8'd0, e);
    push(e,     "zero_e0", 8'd0, 8'd0, 0, 1, 1, 0);
    push(e + 1, "zero_e1", 8'd0, 8'd0, 0, 0, 1, 0);
    wait_until(e + 6);
    chk("zero_timeout_pulses", to_cnt, 1);
    chk("zero_running_seen", int'(run_seen), 0);

    // max_time changes mid-round are ignored; restart collides with expiry
    to_cnt = 0;
    start_round(8'd4, e2);
    max_time = 8'd9;
    push(e2,      "mid_e0",  8'd0, 8'd4, 1, 0, 0, 0);
    push(e2 + 8,  "mid_e8",  8'd2, 8'd4, 1, 0, 0, 0);
    push(e2 + 15, "mid_e15", 8'd3, 8'd4, 1, 0, 0, 0);
    wait_until(e2 + 15);
    start_round(8'd9, e3);
    chk("restart_edge", e3, e2 + 16);
    push(e3,     "rs_e0", 8'd0, 8'd9, 1, 0, 0, 0);
    push(e3 + 4, "rs_e4", 8'd1, 8'd9, 1, 0, 0, 0);
    wait_until(e3 + 5);
    chk("rs_timeout_pulses", to_cnt, 0);

    // Asynchronous reset mid-round
    #2;
    rst = 1'b1;
    #1;
    cmp("arst_now", 8'd0, 8'd0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    step(); step();
    cmp("arst_after", 8'd0, 8'd0, 0, 0, 0, 0);

    // Start after reset; DONE ignores stop and pause
    to_cnt = 0;
    start_round(8'd1, e4);
    push(e4,     "pr_e0", 8'd0, 8'd1, 1, 0, 0, 0);
    push(e4 + 4, "pr_e4", 8'd1, 8'd1, 0, 1, 1, 0);
    push(e4 + 5, "pr_e5", 8'd1, 8'd1, 0, 0, 1, 0);
    push(e4 + 8, "pr_e8", 8'd1, 8'd1, 0, 0, 1, 0);
    wait_until(e4 + 5);
    stop = 1'b1; pause = 1'b1;
    step();
    stop = 1'b0;
    step();
    pause = 1'b0;
    wait_until(e4 + 10);
    chk("pr_timeout_pulses", to_cnt, 1);

    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/round_timer.md
# round_timer

Per-round countdown source for the binary-counting game. It sits directly upstream of the blink controller and converts the system clock into game-time ticks. It counts `timer_value` from 0 up to a per-round limit latched at round start, and drives that controller's `enable`, `timer_value` and `MAXTIME` inputs. It also signals the game FSM when a round ends by timeout or by player answer.

## Interface

Parameters:
- `TICK_DIV`, default 1000: clk cycles per game-time tick (1 s at 1 kHz). Legal range 2..65535.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle pulse; begins or restarts a round.
- `stop` in 1: one-cycle pulse; player answered, ends the round.
- `pause` in 1: level; freezes the round while high.
- `max_time` in 8: round length in ticks; sampled only on `start`.
- `timer_value` out 8: elapsed ticks; feeds blink controller `timer_value`.
- `max_time_q` out 8: latched round length; feeds blink controller `MAXTIME`.
- `running` out 1: high in RUN and PAUSE; feeds blink controller `enable`.
- `timeout` out 1: one-cycle pulse when the round expires.
- `expired` out 1: level; the round ended by timeout.
- `stopped` out 1: level; the round ended by `stop`.

## Operation

- States: IDLE, RUN, PAUSE, DONE. Reset enters IDLE.
- Reset values: all outputs 0; prescaler 0.
- Event priority each cycle: `start` > `stop` > tick/expiry > `pause`.
- `start` in any state:
  - clears `timer_value`, the prescaler, `expired` and `stopped`;
  - latches `max_time` into `max_time_q`;
  - enters RUN.
- `start` with `max_time==0`: enters DONE directly with `expired=1` and `timeout` pulsed. `running` stays 0.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and `timer_value` increments.
  - If the incremented value equals `max_time_q`, enter DONE with `expired=1` and pulse `timeout`.
  - `stop` enters DONE with `stopped=1`. `timer_value` holds its pre-stop value and no increment occurs that cycle.
  - `pause` high with no higher-priority event enters PAUSE. The prescaler and `timer_value` hold.
- PAUSE:
  - `pause` low returns to RUN; prescaler counting resumes from the held value.
  - `stop` enters DONE with `stopped=1`.
- DONE:
  - `timer_value`, `max_time_q`, `expired` and `stopped` hold until `start` or `rst`.
  - `stop` and `pause` are ignored.
- IDLE: `stop` and `pause` are ignored.
- `timer_value` never exceeds `max_time_q` and never wraps.
- `max_time` changes mid-round are ignored.

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- `start` sampled at edge E:
  - `running=1` and `timer_value=0` from E.
  - `timer_value=n` from edge E + n·TICK_DIV, provided no pause occurs.
- Expiry: at edge E + max·TICK_DIV:
  - `timer_value=max`, `running=0`, `expired=1`;
  - `timeout=1` for exactly the one cycle following that edge.
- Pause: each cycle spent in PAUSE delays every later tick by exactly one cycle.
- `stop` sampled at edge S: `running=0` and `stopped=1` from S.
- `stop` coinciding with the final tick: stop wins; `timeout` stays 0 and `expired` stays 0.
- `start` coinciding with `stop` or expiry: start wins; the round restarts and no `timeout` pulse occurs.
- `rst` asserted mid-round: all outputs go to 0 immediately (asynchronous); IDLE after release.

## Structure

- Shared package `game_pkg`:
  - state enum `round_state_t` (IDLE/RUN/PAUSE/DONE);
  - `TICK_DIV_DEFAULT = 1000`;
  - `TIME_W = 8`.
- Sub-module `tick_prescaler`:
  - 16-bit counter with `en`, `clr`, and a one-cycle `tick` output when the count reaches TICK_DIV-1;
  - `en` = state is RUN; `clr` = `start`.
- The top level holds the FSM, the `timer_value`/`max_time_q` registers and the status flags.

## Test plan

Use TICK_DIV=4 in simulation.

- Normal expiry: reset, `start` with `max_time=3` → `timer_value` reads 1, 2, 3 at E+4, E+8, E+12; `timeout` high for one cycle after E+12; `running` 0; `expired=1`.
- Answer: `start` with `max_time=5`, then `stop` at E+6 → `timer_value=1`, `stopped=1`, `timeout` never asserted; value holds for 20 cycles.
- Pause: `max_time=2`, `pause` high for 3 cycles starting E+2 → tick 1 at E+7, expiry at E+11.
- Collision: `stop` at E+8 with `max_time=2` → `timer_value=1`, `stopped=1`, `expired=0`, no `timeout`.
- Zero length and restart: `start` with `max_time=0` → `expired=1`, single `timeout` pulse, `running` never 1. Then `start` with `max_time=4`, and change `max_time` to 9 mid-round → `max_time_q` stays 4.
- Async reset: assert `rst` at E+5 mid-round → all outputs 0 before the next edge; after release, `start` behaves as from reset.
